alu_seq: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_mul_iter.sv | 71 +++++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and control FSM states for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_SETLO = 4'd2;
  localparam logic [OP_W-1:0] OP_SETHI = 4'd3;
  localparam logic [OP_W-1:0] OP_ADC   = 4'd4;
  localparam logic [OP_W-1:0] OP_SBB   = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR   = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd8;
  localparam logic [OP_W-1:0] OP_PASS  = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the issuing control FSM and the sequential ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] operanda;
  logic [WIDTH-1:0] operandb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output start, op, operanda, operandb,
    input  busy, done, result, flag_z, flag_c, flag_n, flag_v
  );

  modport slave (
    input  start, op, operanda, operandb,
    output busy, done, result, flag_z, flag_c, flag_n, flag_v
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic               run_q,   run_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q,  prod_d;

  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               last;

  // Upper half accumulates; lower half holds the remaining multiplier bits,
  // so the product shifts in from the top as the multiplier shifts out.
  always_comb begin
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {step_sum, prod_q[WIDTH-1:1]};
    last      = run_q && (cnt_q == CW'(WIDTH - 1));
  end

  assign done_o = last;
  assign prod_o = prod_next;

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (start_i) begin
      run_d   = 1'b1;
      cnt_d   = '0;
      mcand_d = b_i;
      prod_d  = {{WIDTH{1'b0}}, a_i};
    end else if (run_q) begin
      prod_d = prod_next;
      if (last) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with persistent flags, start/busy/done handshake
// and an optional multi-cycle multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int unsigned HALF = WIDTH / 2;

  state_t           state_q,  state_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign op_a   = bus.operanda;
  assign op_b   = bus.operandb;
  assign is_mul = MUL_EN && (bus.op == OP_MUL);

  always_comb begin
    sum     = '0;
    alu_res = op_a;
    alu_c   = c_q;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, op_a} + {1'b0, op_b}
                + ((bus.op == OP_ADC) ? {{WIDTH{1'b0}}, c_q} : '0);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        // Bit WIDTH of the extended difference is the borrow out.
        sum     = {1'b0, op_a} - {1'b0, op_b}
                - ((bus.op == OP_SBB) ? {{WIDTH{1'b0}}, c_q} : '0);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SETLO: alu_res = {op_a[WIDTH-1:HALF], op_b[HALF-1:0]};
      OP_SETHI: alu_res = {op_b[HALF-1:0], op_a[HALF-1:0]};
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      default: alu_res = op_a;
    endcase
  end

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start_i (mul_start),
      .a_i     (op_a),
      .b_i     (op_b),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
    );
  end else begin : g_nomul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    result_d  = result_q;
    z_d       = z_q;
    c_d       = c_q;
    n_d       = n_q;
    v_d       = v_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            result_d = alu_res;
            z_d      = (alu_res == '0);
            c_d      = alu_c;
            n_d      = alu_res[WIDTH-1];
            v_d      = alu_v;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          z_d      = (mul_prod[WIDTH-1:0] == '0);
          c_d      = |mul_prod[2*WIDTH-1:WIDTH];
          n_d      = mul_prod[WIDTH-1];
          v_d      = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign bus.busy   = (state_q == ST_MUL);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_z = z_q;
  assign bus.flag_c = c_q;
  assign bus.flag_n = n_q;
  assign bus.flag_v = v_q;

endmodule
